// File: rtl/axi_default_slave.sv
// Default AXI slave: completes every unmapped read or write burst with a DECERR
// response. Read and write channels run as two independent FSMs.
module axi_default_slave #(
  parameter int IDW  = 8,
  parameter int DW   = 32,
  parameter int LENW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IDW-1:0]  ARID_S,
  input  logic [LENW-1:0] ARLEN_S,
  input  logic            ARVALID_S,
  output logic            ARREADY_S,
  output logic [IDW-1:0]  RID_S,
  output logic [DW-1:0]   RDATA_S,
  output logic [1:0]      RRESP_S,
  output logic            RLAST_S,
  output logic            RVALID_S,
  input  logic            RREADY_S,
  input  logic [IDW-1:0]  AWID_S,
  input  logic            AWVALID_S,
  output logic            AWREADY_S,
  input  logic            WLAST_S,
  input  logic            WVALID_S,
  output logic            WREADY_S,
  output logic [IDW-1:0]  BID_S,
  output logic [1:0]      BRESP_S,
  output logic            BVALID_S,
  input  logic            BREADY_S,
  output logic            dbg_r_state_o,
  output logic [1:0]      dbg_w_state_o
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where VALID and READY are both high; an asserted VALID here keeps its
  // payload stable until that transfer completes.

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  r_state_e        r_state_q, r_state_d;
  logic [IDW-1:0]  rid_q, rid_d;
  logic [LENW-1:0] rlen_q, rlen_d;
  logic [LENW-1:0] rcnt_q, rcnt_d;
  logic            r_last;

  w_state_e        w_state_q, w_state_d;
  logic [IDW-1:0]  wid_q, wid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      w_state_q <= W_IDLE;
      wid_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
    end
  end

  // The last beat leaves R_DATA before rcnt_q could wrap, so LEN=all-ones is safe.
  assign r_last = (rcnt_q == rlen_q);

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    ARREADY_S = 1'b0;
    RVALID_S  = 1'b0;
    RLAST_S   = 1'b0;
    RID_S     = '0;
    RRESP_S   = 2'b00;
    RDATA_S   = '0;
    case (r_state_q)
      R_IDLE: begin
        ARREADY_S = 1'b1;
        if (ARVALID_S) begin
          rid_d     = ARID_S;
          rlen_d    = ARLEN_S;
          rcnt_d    = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        RVALID_S = 1'b1;
        RLAST_S  = r_last;
        RID_S    = rid_q;
        RRESP_S  = RESP_DECERR;
        if (RREADY_S) begin
          if (r_last) r_state_d = R_IDLE;
          else        rcnt_d    = rcnt_q + LENW'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write beats are swallowed without a length check; only WLAST ends the burst.
  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    AWREADY_S = 1'b0;
    WREADY_S  = 1'b0;
    BVALID_S  = 1'b0;
    BID_S     = '0;
    BRESP_S   = 2'b00;
    case (w_state_q)
      W_IDLE: begin
        AWREADY_S = 1'b1;
        if (AWVALID_S) begin
          wid_d     = AWID_S;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        WREADY_S = 1'b1;
        if (WVALID_S && WLAST_S) w_state_d = W_RESP;
      end
      W_RESP: begin
        BVALID_S = 1'b1;
        BID_S    = wid_q;
        BRESP_S  = RESP_DECERR;
        if (BREADY_S) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign dbg_r_state_o = r_state_q;
  assign dbg_w_state_o = w_state_q;

endmodule

// File: doc/axi_default_slave.md
Name: axi_default_slave

Overview:
- Default slave (slave index 0) behind the AXI crossbar arbiter. It receives every read or write address that decodes to no mapped region.
- Each transaction completes as a protocol-legal AXI burst with DECERR response, so an errant master never hangs the bus.
- Provides the ARREADY/AWREADY, RVALID/RLAST and BVALID inputs the arbiter uses to open and close the slave-0 connection.
- Read and write channels are handled by two independent state machines.

Parameters:
- IDW, 8, slave-side ID width (master ID plus master index bits).
- DW, 32, data width.
- LENW, 4, burst-length field width; beats = LEN+1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- ARID_S  input  IDW  read address ID.
- ARLEN_S  input  LENW  read burst length.
- ARVALID_S  input  1  read address valid.
- ARREADY_S  output  1  read address ready.
- RID_S  output  IDW  read ID.
- RDATA_S  output  DW  read data; always 0.
- RRESP_S  output  2  read response; always 2'b11 while RVALID.
- RLAST_S  output  1  last read beat.
- RVALID_S  output  1  read data valid.
- RREADY_S  input  1  read data ready.
- AWID_S  input  IDW  write address ID.
- AWVALID_S  input  1  write address valid.
- AWREADY_S  output  1  write address ready.
- WLAST_S  input  1  last write beat.
- WVALID_S  input  1  write data valid.
- WREADY_S  output  1  write data ready.
- BID_S  output  IDW  write response ID.
- BRESP_S  output  2  write response; always 2'b11 while BVALID.
- BVALID_S  output  1  write response valid.
- BREADY_S  input  1  write response ready.

Behaviour:
- Reset: synchronous, active-high, sampled on posedge clk.
  - Both FSMs go to IDLE; internal ID/len/count registers clear to 0.
  - Outputs after reset: ARREADY_S=1, AWREADY_S=1; RVALID_S, RLAST_S, WREADY_S, BVALID_S = 0; RID_S, BID_S = 0; RRESP_S, BRESP_S = 0; RDATA_S = 0.
  - Reset mid-burst abandons the transaction with no further beats. This is legal only because the whole interconnect resets together.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY_S=1, RVALID_S=0. On ARVALID_S: latch ARID_S into rid, ARLEN_S into rlen, clear cnt, go to R_DATA next cycle.
  - Address-to-first-beat latency is 1 cycle.
  - R_DATA: ARREADY_S=0, RVALID_S=1, RID_S=rid, RRESP_S=2'b11, RDATA_S=0, RLAST_S=(cnt==rlen).
  - On RVALID_S&&RREADY_S: if RLAST_S, go to R_IDLE; otherwise cnt+1.
  - RREADY_S low: all R outputs hold stable and cnt holds.
  - cnt is LENW bits wide. LEN=2^LENW-1 gives 2^LENW beats with no overflow, because the last beat exits before cnt wraps.
  - After the last handshake, ARREADY_S reasserts the next cycle. The idle cycle between bursts is mandatory.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: AWREADY_S=1, WREADY_S=0, BVALID_S=0. On AWVALID_S: latch AWID_S into wid, go to W_DATA.
  - W data presented before AW is accepted is not accepted (WREADY_S=0).
  - W_DATA: AWREADY_S=0, WREADY_S=1. Every WVALID_S beat is accepted and discarded. On WVALID_S&&WLAST_S, go to W_RESP. There is no length check.
  - W_RESP: WREADY_S=0, BVALID_S=1, BID_S=wid, BRESP_S=2'b11. Hold until BREADY_S; on handshake go to W_IDLE.
  - AW to B latency is at least 2 cycles for a single beat.
- Concurrency:
  - AR and AW may be accepted in the same cycle; the two FSMs share no state.
  - A new AR/AW is never accepted while its own FSM is busy (no outstanding transactions).
- RRESP_S and BRESP_S drive 0 whenever their valid is low.

Test Plan:
- Reset, then ARID=8'h15, ARLEN=0, ARVALID pulse with RREADY=1 -> next cycle RVALID=1, RLAST=1, RID=8'h15, RRESP=2'b11, RDATA=0. Cycle after: RVALID=0, ARREADY=1.
- ARLEN=3, RREADY toggled 1,0,0,1,1,0,1 -> exactly 4 handshakes; RLAST only on the 4th; RID/RRESP stable during stalls.
- ARLEN=15 -> 16 beats, RLAST on beat 16 only; FSM returns to R_IDLE.
- AWID=8'h2A, then 3 W beats with WLAST on the 3rd, BREADY held low 5 cycles -> BVALID=1, BID=8'h2A, BRESP=2'b11 steady 5 cycles; cleared the cycle after BREADY=1; AWREADY=1 again.
- AR (ID 8'h01, LEN 1) and AW (ID 8'h02) in the same cycle -> both accepted; read returns 2 DECERR beats ID 8'h01 and write returns B ID 8'h02, in any interleave.
- rst asserted during beat 2 of an ARLEN=7 read and while in W_DATA -> next cycle RVALID=0, WREADY=0, BVALID=0, ARREADY=1, AWREADY=1.
